elixirchip_es1_spu_mulsu_arbiter: RTL

ELIXIRCHIP_ES1_SPU_MULSU_ARBITER -- requirements
Module: elixirchip_es1_spu_mulsu_arbiter

---
 rtl/elixirchip_es1_spu_pkg.sv | 41 ++++
 rtl/elixirchip_es1_spu_op_mulsu.sv | 63 ++++++
 rtl/elixirchip_es1_spu_mulsu_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/elixirchip_es1_spu_pkg.sv
// rtl/elixirchip_es1_spu_pkg.sv - shared widths and round-robin helper for the SPU arbiters
package elixirchip_es1_spu_pkg;

  // Widest requester vector the round-robin helper handles.
  localparam int RR_MAX = 8;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_bits(input int num);
    return (num <= 2) ? 1 : $clog2(num);
  endfunction

  // Width of an in-flight counter that must hold 0..latency.
  function automatic int count_bits(input int latency);
    return $clog2(latency + 2);
  endfunction

  // One-hot grant for the first set request at or after ptr, wrapping at num.
  function automatic logic [RR_MAX-1:0] rr_grant(
    input logic [RR_MAX-1:0] req,
    input logic [2:0]        ptr,
    input logic [3:0]        num
  );
    logic [RR_MAX-1:0] grant;
    logic [3:0]        idx;
    logic              found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= num) begin
        idx = idx - num;
      end
      if (4'(k) < num && !found && req[idx[2:0]]) begin
        grant[idx[2:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_mulsu.sv
// rtl/elixirchip_es1_spu_op_mulsu.sv - pipelined signed x unsigned multiplier with right shift
module elixirchip_es1_spu_op_mulsu #(
  parameter int LATENCY      = 3,
  parameter int S_DATA0_BITS = 8,
  parameter int S_DATA1_BITS = 8,
  parameter int M_DATA_BITS  = 16,
  parameter int DATA_SHIFT   = 0,
  parameter     DEVICE       = "RTL",
  parameter     SIMULATION   = "false",
  parameter     DEBUG        = "false"
) (
  input  logic                    reset,
  input  logic                    clk,
  input  logic                    cke,
  input  logic                    s_clear,
  input  logic [S_DATA0_BITS-1:0] s_data0,
  input  logic [S_DATA1_BITS-1:0] s_data1,
  input  logic                    s_valid,
  output logic [M_DATA_BITS-1:0]  m_data
);

  // On a real device the first stage holds across bubbles to cut toggling;
  // in plain RTL or debug builds every stage simply follows its input.
  localparam bit HOLD_ON_BUBBLE = (DEVICE != "RTL") && (SIMULATION == "false") && (DEBUG == "false");

  // Wide enough that neither the product nor the sign extension to M_DATA_BITS overflows.
  localparam int PROD_BITS = S_DATA0_BITS + S_DATA1_BITS + M_DATA_BITS + 1;

  logic signed [PROD_BITS-1:0]   op0;
  logic signed [PROD_BITS-1:0]   op1;
  logic signed [PROD_BITS-1:0]   product_full;
  logic        [M_DATA_BITS-1:0] product;

  assign op0          = {{(PROD_BITS - S_DATA0_BITS){s_data0[S_DATA0_BITS-1]}}, s_data0};
  assign op1          = {{(PROD_BITS - S_DATA1_BITS){1'b0}}, s_data1};
  assign product_full = op0 * op1;
  assign product      = M_DATA_BITS'(product_full >>> DATA_SHIFT);

  if (LATENCY == 0) begin : g_comb
    assign m_data = product;
  end else begin : g_pipe
    logic [M_DATA_BITS-1:0] stage [LATENCY];

    // Result pipeline: advances only with cke, cleared by reset or s_clear.
    always_ff @(posedge clk) begin
      if (reset || s_clear) begin
        for (int i = 0; i < LATENCY; i++) begin
          stage[i] <= '0;
        end
      end else if (cke) begin
        if (s_valid || !HOLD_ON_BUBBLE) begin
          stage[0] <= product;
        end
        for (int i = 1; i < LATENCY; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign m_data = stage[LATENCY-1];
  end

endmodule

// File: rtl/elixirchip_es1_spu_mulsu_arbiter.sv
// rtl/elixirchip_es1_spu_mulsu_arbiter.sv - round-robin shared signed x unsigned multiplier
module elixirchip_es1_spu_mulsu_arbiter
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LATENCY      = 3,
  parameter int S_DATA0_BITS = 8,
  parameter int S_DATA1_BITS = 8,
  parameter int M_DATA_BITS  = 16,
  parameter int DATA_SHIFT   = 0,
  parameter     DEVICE       = "RTL",
  parameter     SIMULATION   = "false",
  parameter     DEBUG        = "false",
  localparam int ID_BITS     = id_bits(NUM_REQ),
  localparam int COUNT_BITS  = count_bits(LATENCY)
) (
  input  logic                            reset,
  input  logic                            clk,
  input  logic                            cke,
  input  logic [NUM_REQ*S_DATA0_BITS-1:0] s_data0,
  input  logic [NUM_REQ*S_DATA1_BITS-1:0] s_data1,
  input  logic [NUM_REQ-1:0]              s_valid,
  output logic [NUM_REQ-1:0]              s_ready,
  output logic [M_DATA_BITS-1:0]          m_data,
  output logic [ID_BITS-1:0]              m_id,
  output logic                            m_valid,
  output logic [COUNT_BITS-1:0]           busy_count
);

  logic [ID_BITS-1:0]      ptr;
  logic [ID_BITS-1:0]      sel_id;
  logic [S_DATA0_BITS-1:0] sel_data0;
  logic [S_DATA1_BITS-1:0] sel_data1;
  logic                    transfer;

  // Combinational round-robin grant starting at ptr; silent during reset or cke=0.
  always_comb begin
    s_ready = '0;
    if (cke && !reset) begin
      s_ready = NUM_REQ'(rr_grant(RR_MAX'(s_valid), 3'(ptr), 4'(NUM_REQ)));
    end
  end

  assign transfer = |s_ready;

  // Encode the one-hot grant and steer that requester's operands to the multiplier.
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_ready[i]) begin
        sel_id = ID_BITS'(i);
      end
    end
    sel_data0 = s_data0[sel_id*S_DATA0_BITS +: S_DATA0_BITS];
    sel_data1 = s_data1[sel_id*S_DATA1_BITS +: S_DATA1_BITS];
  end

  // Search pointer moves just past the requester that was served.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (sel_id == ID_BITS'(NUM_REQ - 1)) ? '0 : sel_id + ID_BITS'(1);
    end
  end

  elixirchip_es1_spu_op_mulsu #(
    .LATENCY      (LATENCY),
    .S_DATA0_BITS (S_DATA0_BITS),
    .S_DATA1_BITS (S_DATA1_BITS),
    .M_DATA_BITS  (M_DATA_BITS),
    .DATA_SHIFT   (DATA_SHIFT),
    .DEVICE       (DEVICE),
    .SIMULATION   (SIMULATION),
    .DEBUG        (DEBUG)
  ) u_mul (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
    .s_clear (1'b0),
    .s_data0 (sel_data0),
    .s_data1 (sel_data1),
    .s_valid (transfer),
    .m_data  (m_data)
  );

  if (LATENCY == 0) begin : g_tag_comb
    assign m_valid    = transfer;
    assign m_id       = sel_id;
    assign busy_count = '0;
  end else begin : g_tag_pipe
    logic [LATENCY-1:0]    tag_valid;
    logic [ID_BITS-1:0]    tag_id [LATENCY];
    logic [COUNT_BITS-1:0] count;

    // Tag pipeline shadows the multiplier stages; idle slots carry id 0.
    always_ff @(posedge clk) begin
      if (reset) begin
        tag_valid <= '0;
        for (int i = 0; i < LATENCY; i++) begin
          tag_id[i] <= '0;
        end
      end else if (cke) begin
        tag_valid[0] <= transfer;
        tag_id[0]    <= sel_id;
        for (int i = 1; i < LATENCY; i++) begin
          tag_valid[i] <= tag_valid[i-1];
          tag_id[i]    <= tag_id[i-1];
        end
      end
    end

    // In-flight count: +1 on issue, -1 on retire, unchanged when both coincide.
    always_ff @(posedge clk) begin
      if (reset) begin
        count <= '0;
      end else if (cke) begin
        if (transfer && !m_valid) begin
          count <= count + COUNT_BITS'(1);
        end else if (!transfer && m_valid) begin
          count <= count - COUNT_BITS'(1);
        end
      end
    end

    assign m_valid    = tag_valid[LATENCY-1];
    assign m_id       = tag_id[LATENCY-1];
    assign busy_count = count;
  end

endmodule
